// File: rtl/fetch_queue.sv
// Instruction fetch stage: one outstanding req/ack memory fetch feeding a small {pc,instr} FIFO.
// Presents the head entry to decode and flushes/refetches on redirect from execute.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus8_d
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t          state;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fetch_pc;

    logic            pop;
    logic            push;
    logic            credit;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   remain;
    logic [PW-1:0]   rd_next;
    entry_t          head;
    logic [31:0]     redirect_aligned;
    logic [31:0]     fetch_inc;

    // Next-cycle queue occupancy and head; a push into a queue that drains this cycle becomes the head.
    always_comb begin
        pop              = valid_d & ~stall_d;
        push             = (state == REQ) && imem_ack && !redirect_valid;
        count_next       = count;
        if (redirect_valid)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
        remain           = count - CW'(pop);
        rd_next          = rd_ptr + PW'(pop);
        head             = (remain == '0) ? {imem_addr, imem_rdata} : mem[rd_next];
        credit           = count_next < CW'(DEPTH);
        redirect_aligned = redirect_pc & ~32'h3;
        fetch_inc        = fetch_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {imem_addr, imem_rdata};
    end

    // Queue pointers and registered decode outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            valid_d    <= 1'b0;
            instr_d    <= NOP_INSTR;
            pc_d       <= 32'h0;
            pc_plus8_d <= 32'h8;
        end else if (redirect_valid) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr  <= rd_next;
            count   <= count_next;
            valid_d <= (count_next != '0);
            if (count_next != '0) begin
                instr_d    <= head.instr;
                pc_d       <= head.pc;
                pc_plus8_d <= head.pc + 32'd8;
            end else begin
                instr_d <= NOP_INSTR;
            end
        end
    end

    // Fetch FSM; DROP waits out a request that a redirect made stale, since req cannot be retracted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_aligned;
                    end else if (credit) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_aligned;
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_inc;
                        if (credit) begin
                            imem_addr <= fetch_inc;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (redirect_valid)
                        fetch_pc <= redirect_aligned;
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
